// File: rtl/i2s_fifo_dma.sv
// i2s_fifo_dma: moves one BURST of words from the I2S FIFO data register into
// a ring buffer in system memory for every FIFO-full (or software) trigger.
// Configuration and status are reached through an AHB-Lite slave port, and the
// copy itself is done as single-word read/write pairs on an AHB-Lite master port.
module i2s_fifo_dma #(
    parameter int BURST = 16,
    parameter int LENW  = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        S_HSEL,
    input  logic [31:0] S_HADDR,
    input  logic [1:0]  S_HTRANS,
    input  logic        S_HWRITE,
    input  logic [2:0]  S_HSIZE,
    input  logic [31:0] S_HWDATA,
    input  logic        S_HREADY,
    output logic [31:0] S_HRDATA,
    output logic        S_HREADYOUT,
    output logic [31:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic        M_HWRITE,
    output logic [2:0]  M_HSIZE,
    output logic [31:0] M_HWDATA,
    input  logic [31:0] M_HRDATA,
    input  logic        M_HREADY,
    input  logic        M_HRESP,
    input  logic        trig,
    output logic        IRQ
);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA} state_t;

    // Slave address phase
    logic [7:0]      r_s_addr;
    logic            r_s_wr;
    // Configuration / status
    logic            r_en, r_circ, r_swtrig;
    logic [2:0]      r_ie;
    logic [31:0]     r_src, r_dst;
    logic [LENW-1:0] r_len, r_idx;
    logic            r_half, r_done, r_ovr, r_err;
    // Master side
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_hold, r_haddr;
    logic [1:0]      r_htrans;
    logic            r_hwrite;
    logic            r_irq;

    logic            w_wr_ctrl, w_wr_src, w_wr_dst, w_wr_len, w_wr_stat;
    logic            w_busy, w_trig_any, w_hit_half, w_hit_len, w_en_after;
    logic [LENW-1:0] w_idx_inc;
    logic [CW-1:0]   w_cnt_dec;
    logic [31:0]     w_waddr;
    logic            w_unused;

    assign w_wr_ctrl  = r_s_wr && (r_s_addr == 8'h00);
    assign w_wr_src   = r_s_wr && (r_s_addr == 8'h04);
    assign w_wr_dst   = r_s_wr && (r_s_addr == 8'h08);
    assign w_wr_len   = r_s_wr && (r_s_addr == 8'h0C);
    assign w_wr_stat  = r_s_wr && (r_s_addr == 8'h10);

    assign w_busy     = (r_state != S_IDLE);
    assign w_trig_any = trig | r_swtrig;
    assign w_idx_inc  = r_idx + LENW'(1);
    assign w_hit_half = (w_idx_inc == (r_len >> 1));
    assign w_hit_len  = (w_idx_inc == r_len);
    assign w_cnt_dec  = r_cnt - CW'(1);
    assign w_waddr    = r_dst + {{(30-LENW){1'b0}}, r_idx, 2'b00};
    // EN as it will stand after this edge: a CPU write or a one-shot ring wrap may drop it
    assign w_en_after = (w_wr_ctrl ? S_HWDATA[0] : r_en) & ~(w_hit_len & ~r_circ);

    assign S_HREADYOUT = 1'b1;
    assign M_HSIZE     = 3'b010;
    assign M_HADDR     = r_haddr;
    assign M_HTRANS    = r_htrans;
    assign M_HWRITE    = r_hwrite;
    assign M_HWDATA    = r_hold;
    assign IRQ         = r_irq;
    assign w_unused    = &{1'b0, S_HADDR[31:8], S_HTRANS[0], S_HSIZE};

    // Register the slave address phase whenever the bus is ready
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_s_addr <= '0;
            r_s_wr   <= 1'b0;
        end else if (S_HREADY) begin
            r_s_addr <= S_HADDR[7:0];
            r_s_wr   <= S_HSEL & S_HTRANS[1] & S_HWRITE;
        end
    end

    // CPU-only configuration registers; SWTRIG is a one-cycle pulse
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_circ   <= 1'b0;
            r_ie     <= '0;
            r_swtrig <= 1'b0;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
        end else begin
            r_swtrig <= w_wr_ctrl & S_HWDATA[2];
            if (w_wr_ctrl) begin
                r_circ <= S_HWDATA[1];
                r_ie   <= S_HWDATA[6:4];
            end
            if (w_wr_src) r_src <= S_HWDATA;
            if (w_wr_dst) r_dst <= {S_HWDATA[31:2], 2'b00};
            if (w_wr_len) r_len <= S_HWDATA[LENW-1:0];
        end
    end

    // Transfer sequencer plus the registers it shares with the CPU (EN, flags, IDX);
    // hardware set events are assigned after CPU writes so they take priority
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_en     <= 1'b0;
            r_half   <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_err    <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_haddr  <= '0;
            r_htrans <= HT_IDLE;
            r_hwrite <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_en <= S_HWDATA[0];
            if (w_wr_stat) begin
                r_half <= r_half & ~S_HWDATA[1];
                r_done <= r_done & ~S_HWDATA[2];
                r_ovr  <= r_ovr  & ~S_HWDATA[3];
                r_err  <= r_err  & ~S_HWDATA[4];
            end
            if (w_trig_any && w_busy) r_ovr <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_trig_any && r_en && (r_len != '0)) begin
                        r_state  <= S_RADDR;
                        r_cnt    <= CW'(BURST);
                        r_haddr  <= r_src;
                        r_htrans <= HT_NONSEQ;
                        r_hwrite <= 1'b0;
                    end
                end
                S_RADDR: begin
                    if (M_HREADY) begin
                        r_state  <= S_RDATA;
                        r_htrans <= HT_IDLE;
                    end
                end
                S_RDATA: begin
                    if (M_HREADY) begin
                        if (M_HRESP) begin
                            r_err   <= 1'b1;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_hold   <= M_HRDATA;
                            r_state  <= S_WADDR;
                            r_haddr  <= w_waddr;
                            r_htrans <= HT_NONSEQ;
                            r_hwrite <= 1'b1;
                        end
                    end
                end
                S_WADDR: begin
                    if (M_HREADY) begin
                        r_state  <= S_WDATA;
                        r_htrans <= HT_IDLE;
                    end
                end
                S_WDATA: begin
                    if (M_HREADY) begin
                        if (M_HRESP) begin
                            r_err    <= 1'b1;
                            r_en     <= 1'b0;
                            r_state  <= S_IDLE;
                            r_hwrite <= 1'b0;
                        end else begin
                            if (w_hit_half) r_half <= 1'b1;
                            if (w_hit_len) begin
                                r_idx  <= '0;
                                r_done <= 1'b1;
                                if (!r_circ) r_en <= 1'b0;
                            end else begin
                                r_idx <= w_idx_inc;
                            end
                            r_cnt <= w_cnt_dec;
                            if ((w_cnt_dec != '0) && w_en_after) begin
                                r_state  <= S_RADDR;
                                r_haddr  <= r_src;
                                r_htrans <= HT_NONSEQ;
                                r_hwrite <= 1'b0;
                            end else begin
                                r_state  <= S_IDLE;
                                r_hwrite <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Moving the ring restarts it from word 0
            if (w_wr_dst || w_wr_len) r_idx <= '0;
            r_irq <= (|({r_ovr, r_done, r_half} & r_ie)) | r_err;
        end
    end

    // Slave read data, decoded from the registered address
    always_comb begin
        S_HRDATA = 32'hBADD_BEEF;
        case (r_s_addr)
            8'h00: S_HRDATA = {25'b0, r_ie, 2'b00, r_circ, r_en};
            8'h04: S_HRDATA = r_src;
            8'h08: S_HRDATA = r_dst;
            8'h0C: S_HRDATA = {{(32-LENW){1'b0}}, r_len};
            8'h10: S_HRDATA = {27'b0, r_err, r_ovr, r_done, r_half, w_busy};
            8'h14: S_HRDATA = {{(32-LENW){1'b0}}, r_idx};
            default: S_HRDATA = 32'hBADD_BEEF;
        endcase
    end
endmodule

// File: tb/tb_i2s_fifo_dma.sv
// Directed bench for i2s_fifo_dma: a zero/random-wait memory model on the master
// port, register access through the slave port, one line per check on failure.
module tb_i2s_fifo_dma;
    logic        HCLK, HRESETn;
    logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE, M_HREADY, M_HRESP, trig, IRQ;
    logic [2:0]  M_HSIZE;

    localparam logic [31:0] SRC  = 32'h4000_0010;
    localparam logic [31:0] DST  = 32'h2000_0000;
    localparam logic [31:0] DATA = 32'hC0DE_0000;

    i2s_fifo_dma #(.BURST(16), .LENW(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
        .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP),
        .trig(trig), .IRQ(IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory model state
    logic [31:0] mem [64];
    int  cyc = 0, rd_count = 0, wr_num = 0, err_at = 0, wr_in_burst = 0, rd_bad = 0;
    int  waits_total = 0, t_first = 0, t_last = 0, wleft = 0;
    bit  seen_first = 0, wait_mode = 0, pend = 0, pw = 0;
    logic [31:0] pa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int pick();
        return wait_mode ? int'($urandom_range(0, 3)) : 0;
    endfunction

    // Memory model: decides M_HREADY/M_HRDATA/M_HRESP mid-cycle for the next edge
    always @(negedge HCLK) begin
        cyc++;
        M_HRESP = 1'b0;
        if (!HRESETn) begin
            pend = 0;
            M_HREADY = 1'b1;
        end else if (pend) begin
            if (wleft > 0) begin
                M_HREADY = 1'b0; wleft--; waits_total++;
            end else begin
                M_HREADY = 1'b1;
                if (pw) begin
                    wr_num++;
                    if (wr_num == err_at) M_HRESP = 1'b1;
                    else begin
                        mem[((pa - DST) >> 2) & 63] = M_HWDATA;
                        wr_in_burst++;
                        t_last = cyc;
                    end
                end else begin
                    M_HRDATA = DATA + rd_count;
                    rd_count++;
                end
                pend = 0;
                wleft = pick();
            end
        end else if (M_HTRANS == 2'b10) begin
            if (!seen_first) begin seen_first = 1; t_first = cyc; end
            if (wleft > 0) begin
                M_HREADY = 1'b0; wleft--; waits_total++;
            end else begin
                M_HREADY = 1'b1;
                pend = 1; pw = M_HWRITE; pa = M_HADDR;
                if (!M_HWRITE && M_HADDR != SRC) rd_bad++;
                wleft = pick();
            end
        end else begin
            M_HREADY = 1'b1;
        end
    end

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HWRITE = 1'b1; S_HADDR = a;
        @(posedge HCLK); #1;
        S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWRITE = 1'b0; S_HWDATA = d;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge HCLK); #1;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HWRITE = 1'b0; S_HADDR = a;
        @(posedge HCLK); #1;
        S_HSEL = 1'b0; S_HTRANS = 2'b00;
        d = S_HRDATA;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expv);
        logic [31:0] d;
        ahb_read(a, d);
        chk(tag, d, expv);
    endtask

    task automatic pulse_trig();
        @(posedge HCLK); #1 trig = 1'b1;
        @(posedge HCLK); #1 trig = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        d = 32'h1;
        for (int k = 0; k < 300; k++) begin
            ahb_read(32'h10, d);
            if (!d[0]) break;
        end
        chk(tag, {31'b0, d[0]}, 32'h0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic found;
        HRESETn = 1'b0; trig = 1'b0;
        S_HSEL = 1'b0; S_HADDR = '0; S_HTRANS = 2'b00; S_HWRITE = 1'b0;
        S_HSIZE = 3'b010; S_HWDATA = '0; S_HREADY = 1'b1;
        M_HREADY = 1'b1; M_HRESP = 1'b0; M_HRDATA = '0;
        clear_mem();

        // Reset state
        repeat (3) @(posedge HCLK); #1;
        chk("rst_htrans", 32'(M_HTRANS), 32'h0);
        chk("rst_haddr", M_HADDR, 32'h0);
        chk("rst_hwrite", 32'(M_HWRITE), 32'h0);
        chk("rst_hwdata", M_HWDATA, 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("hsize", 32'(M_HSIZE), 32'h2);
        chk("hreadyout", 32'(S_HREADYOUT), 32'h1);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        rd_chk("rst_ctrl", 32'h00, 32'h0);
        rd_chk("rst_status", 32'h10, 32'h0);
        rd_chk("rst_idx", 32'h14, 32'h0);
        rd_chk("unmapped", 32'h18, 32'hBADD_BEEF);

        // Configuration; DST low bits forced to zero
        ahb_write(32'h04, SRC);
        ahb_write(32'h08, DST | 32'h3);
        ahb_write(32'h0C, 32'd32);
        rd_chk("src_rb", 32'h04, SRC);
        rd_chk("dst_rb", 32'h08, DST);
        rd_chk("len_rb", 32'h0C, 32'd32);

        // Trigger with EN=0 is ignored
        pulse_trig();
        repeat (4) @(posedge HCLK);
        chk("ign_reads", rd_count, 0);
        rd_chk("ign_status", 32'h10, 32'h0);

        // Burst 1: LEN=32, one-shot
        ahb_write(32'h00, 32'h1);
        seen_first = 0; waits_total = 0; wr_in_burst = 0; base = rd_count;
        pulse_trig();
        chk("lat_htrans", 32'(M_HTRANS), 32'h2);
        chk("lat_haddr", M_HADDR, SRC);
        wait_idle("b1_idle");
        chk("b1_cycles", t_last - t_first + 1, 64);
        chk("b1_words", wr_in_burst, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("b1_mem%0d", i), mem[i], DATA + base + i);
        rd_chk("b1_status", 32'h10, 32'h2);
        rd_chk("b1_idx", 32'h14, 32'd16);
        chk("b1_irq", 32'(IRQ), 32'h0);

        // Burst 2: finishes the ring, DONE, EN dropped
        base = rd_count;
        pulse_trig();
        wait_idle("b2_idle");
        for (int i = 0; i < 16; i++) chk($sformatf("b2_mem%0d", 16 + i), mem[16 + i], DATA + base + i);
        rd_chk("b2_status", 32'h10, 32'h6);
        rd_chk("b2_ctrl", 32'h00, 32'h0);
        rd_chk("b2_idx", 32'h14, 32'h0);

        // W1C of all flags
        ahb_write(32'h10, 32'h1E);
        rd_chk("w1c_status", 32'h10, 32'h0);

        // Random wait states plus a trigger while busy (OVR with FAULT enabled)
        ahb_write(32'h08, DST);
        ahb_write(32'h00, 32'h41);
        clear_mem();
        wait_mode = 1; seen_first = 0; waits_total = 0; wr_in_burst = 0; base = rd_count;
        pulse_trig();
        repeat (10) @(posedge HCLK);
        pulse_trig();
        wait_idle("ws_idle");
        wait_mode = 0;
        chk("ws_words", wr_in_burst, 16);
        chk("ws_cycles", t_last - t_first + 1, 64 + waits_total);
        for (int i = 0; i < 16; i++) chk($sformatf("ws_mem%0d", i), mem[i], DATA + base + i);
        rd_chk("ws_status", 32'h10, 32'hA);
        chk("ws_irq", 32'(IRQ), 32'h1);

        // Error response on the 5th write
        ahb_write(32'h10, 32'h1E);
        ahb_write(32'h00, 32'h1);
        ahb_write(32'h08, DST);
        err_at = wr_num + 5; wr_in_burst = 0;
        pulse_trig();
        wait_idle("err_idle");
        err_at = 0;
        chk("err_words", wr_in_burst, 4);
        rd_chk("err_status", 32'h10, 32'h10);
        rd_chk("err_ctrl", 32'h00, 32'h0);
        rd_chk("err_idx", 32'h14, 32'd4);
        chk("err_htrans", 32'(M_HTRANS), 32'h0);
        chk("err_irq", 32'(IRQ), 32'h1);

        // Circular ring of 20 words, three bursts
        ahb_write(32'h10, 32'h1E);
        ahb_write(32'h0C, 32'd20);
        ahb_write(32'h08, DST);
        ahb_write(32'h00, 32'h3);
        clear_mem();
        pulse_trig(); wait_idle("c1_idle");
        pulse_trig(); wait_idle("c2_idle");
        base = rd_count;
        pulse_trig(); wait_idle("c3_idle");
        rd_chk("circ_idx", 32'h14, 32'd8);
        rd_chk("circ_status", 32'h10, 32'h6);
        rd_chk("circ_ctrl", 32'h00, 32'h3);
        chk("circ_mem12", mem[12], DATA + base);
        chk("circ_mem19", mem[19], DATA + base + 7);
        chk("circ_mem0", mem[0], DATA + base + 8);
        chk("circ_mem7", mem[7], DATA + base + 15);
        chk("circ_irq", 32'(IRQ), 32'h0);

        // Reset asserted while the master is in the write address phase
        pulse_trig();
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge HCLK);
            if (M_HTRANS == 2'b10 && M_HWRITE) begin found = 1'b1; break; end
        end
        chk("waddr_found", 32'(found), 32'h1);
        HRESETn = 1'b0;
        #1;
        chk("mrst_htrans", 32'(M_HTRANS), 32'h0);
        chk("mrst_haddr", M_HADDR, 32'h0);
        repeat (2) @(posedge HCLK); #1 HRESETn = 1'b1;
        rd_chk("mrst_ctrl", 32'h00, 32'h0);
        rd_chk("mrst_src", 32'h04, 32'h0);
        rd_chk("mrst_dst", 32'h08, 32'h0);
        rd_chk("mrst_len", 32'h0C, 32'h0);
        rd_chk("mrst_status", 32'h10, 32'h0);
        rd_chk("mrst_idx", 32'h14, 32'h0);
        chk("mrst_irq", 32'(IRQ), 32'h0);
        chk("read_addr", rd_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
